// File: rtl/ysyx_22050133_wbu_pkg.sv
// Shared write-back definitions: widths, ctrl_wb bit map,
// result-source and extension codes, WBU state encoding.
package ysyx_22050133_wbu_pkg;

   localparam int WB_XLEN     = 64;
   localparam int WB_CNT_W    = 64;
   localparam int ctrl_wb_len = 9;

   localparam int CTRL_EBREAK  = 8;
   localparam int CTRL_SRC_HI  = 7;
   localparam int CTRL_SRC_LO  = 6;
   localparam int CTRL_WEN     = 5;
   localparam int CTRL_SEXT_HI = 4;
   localparam int CTRL_SEXT_LO = 0;

   typedef enum logic [1:0] {
      SRC_IMM = 2'd0,
      SRC_ALU = 2'd1,
      SRC_MEM = 2'd2,
      SRC_CSR = 2'd3
   } rd_src_e;

   typedef enum logic [4:0] {
      SX_B  = 5'd0,
      SX_H  = 5'd1,
      SX_W  = 5'd2,
      SX_BU = 5'd3,
      SX_HU = 5'd4,
      SX_WU = 5'd5,
      SX_D  = 5'd6
   } rd_sext_e;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/ysyx_22050133_wbu_if.sv
// MEM -> WB handshake bundle: valid/ready plus retiring instruction.
// master = MEM stage side, slave = WBU side.
interface ysyx_22050133_wbu_if #(
   parameter int XLEN = 64
);
   import ysyx_22050133_wbu_pkg::*;

   logic                   valid;
   logic                   ready;
   logic [XLEN-1:0]        pc;
   logic [ctrl_wb_len-1:0] ctrl_wb;
   logic [4:0]             rd;
   logic [XLEN-1:0]        alu;
   logic [XLEN-1:0]        imm;
   logic [XLEN-1:0]        mem;
   logic [XLEN-1:0]        csr;

   modport master (
      output valid, pc, ctrl_wb, rd, alu, imm, mem, csr,
      input  ready
   );

   modport slave (
      input  valid, pc, ctrl_wb, rd, alu, imm, mem, csr,
      output ready
   );

endinterface

// File: rtl/ysyx_22050133_wb_sext.sv
// Result source mux and width extension (pure combinational).
// Ports: src/sext codes, four candidate values in, data out.
module ysyx_22050133_wb_sext
   import ysyx_22050133_wbu_pkg::*;
#(
   parameter int XLEN = WB_XLEN
) (
   input  logic [1:0]      src,
   input  logic [4:0]      sext,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu,
   input  logic [XLEN-1:0] mem,
   input  logic [XLEN-1:0] csr,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] val;

   always_comb begin
      val = '0;
      unique case (rd_src_e'(src))
         SRC_IMM: val = imm;
         SRC_ALU: val = alu;
         SRC_MEM: val = mem;
         SRC_CSR: val = csr;
         default: val = '0;
      endcase
   end

   // Codes 6 and above keep the full value.
   always_comb begin
      data = val;
      case (sext)
         SX_B:    data = {{(XLEN-8){val[7]}}, val[7:0]};
         SX_H:    data = {{(XLEN-16){val[15]}}, val[15:0]};
         SX_W:    data = {{(XLEN-32){val[31]}}, val[31:0]};
         SX_BU:   data = {{(XLEN-8){1'b0}}, val[7:0]};
         SX_HU:   data = {{(XLEN-16){1'b0}}, val[15:0]};
         SX_WU:   data = {{(XLEN-32){1'b0}}, val[31:0]};
         default: data = val;
      endcase
   end

endmodule

// File: rtl/ysyx_22050133_wbu.sv
// RV64 write-back stage: entry register, rd write port, forwarding,
// ebreak halt FSM and minstret. Ports: clk, rst (async, active-low),
// mem_if (slave handshake), rd*/fwd*/retire*/minstret/halt outputs.
// Option YSYX_22050133_WB_TRACE_EN: trace_mismatch check.
module ysyx_22050133_wbu
   import ysyx_22050133_wbu_pkg::*;
#(
   parameter int XLEN  = WB_XLEN,
   parameter int CNT_W = WB_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   ysyx_22050133_wbu_if.slave mem_if,
   output logic              rdwen,
   output logic [4:0]        rdin,
   output logic [XLEN-1:0]   rddata,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   output logic              retire,
   output logic [XLEN-1:0]   retire_pc,
   output logic [CNT_W-1:0]  minstret,
   output logic              halt,
   output logic              trace_mismatch
);

   wb_state_e state_q, state_d;

   logic                   ent_valid;
   logic [XLEN-1:0]        ent_pc;
   logic [ctrl_wb_len-1:0] ent_ctrl;
   logic [4:0]             ent_rd;
   logic [XLEN-1:0]        ent_alu;
   logic [XLEN-1:0]        ent_imm;
   logic [XLEN-1:0]        ent_mem;
   logic [XLEN-1:0]        ent_csr;
   logic [CNT_W-1:0]       cnt_q;
   logic [XLEN-1:0]        sel_data;
   logic                   ebreak_ret;
   logic                   load;

   assign ebreak_ret   = ent_valid & ent_ctrl[CTRL_EBREAK];
   assign mem_if.ready = (state_q == S_RUN);
   // The ebreak is the last instruction: nothing is taken on the
   // edge that enters HALT.
   assign load = mem_if.valid & mem_if.ready & ~ebreak_ret;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:   if (ebreak_ret) state_d = S_HALT;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_RUN;
         ent_valid <= 1'b0;
         ent_pc    <= '0;
         ent_ctrl  <= '0;
         ent_rd    <= '0;
         ent_alu   <= '0;
         ent_imm   <= '0;
         ent_mem   <= '0;
         ent_csr   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ent_valid <= load;
         if (load) begin
            ent_pc   <= mem_if.pc;
            ent_ctrl <= mem_if.ctrl_wb;
            ent_rd   <= mem_if.rd;
            ent_alu  <= mem_if.alu;
            ent_imm  <= mem_if.imm;
            ent_mem  <= mem_if.mem;
            ent_csr  <= mem_if.csr;
         end
         if (ent_valid) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   ysyx_22050133_wb_sext #(
      .XLEN (XLEN)
   ) u_sext (
      .src  (ent_ctrl[CTRL_SRC_HI:CTRL_SRC_LO]),
      .sext (ent_ctrl[CTRL_SEXT_HI:CTRL_SEXT_LO]),
      .imm  (ent_imm),
      .alu  (ent_alu),
      .mem  (ent_mem),
      .csr  (ent_csr),
      .data (sel_data)
   );

   assign rdwen     = ent_valid & ent_ctrl[CTRL_WEN] & (ent_rd != 5'd0);
   assign rdin      = ent_valid ? ent_rd : 5'd0;
   assign rddata    = ent_valid ? sel_data : '0;
   assign fwd_valid = rdwen;
   assign fwd_rd    = rdin;
   assign fwd_data  = rddata;
   assign retire    = ent_valid;
   assign retire_pc = ent_valid ? ent_pc : '0;
   assign minstret  = cnt_q;
   assign halt      = (state_q == S_HALT);

`ifdef YSYX_22050133_WB_TRACE_EN
   assign trace_mismatch = rdwen & (rdin == 5'd0);
`else
   assign trace_mismatch = 1'b0;
`endif

endmodule
